fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage of the RV32I core. Holds the PC and issues one
//   instruction-memory request at a time. Hands each fetched word to decode
//   over a valid/ready handshake. Consumes the branch decision from the
//   branch compare unit (take_branch) and the jump signal to redirect the PC.
//   Any in-flight or held wrong-path instruction is discarded on redirect.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC fetched first after reset release
// PORTS
//   clk_i            in   1   core clock, all state on rising edge
//   rst_ni           in   1   asynchronous active-low reset
//   take_branch_i    in   1   branch taken, from the compare unit
//   jump_i           in   1   JAL/JALR resolved
//   target_i         in   32  redirect target (branch or jump)
//   imem_req_o       out  1   memory request
//   imem_addr_o      out  32  request address (= pc_q)
//   imem_gnt_i       in   1   request accepted
//   imem_rvalid_i    in   1   read data valid (>=1 cycle after gnt)
//   imem_rdata_i     in   32  instruction word
//   instr_valid_o    out  1   instruction available to decode
//   instr_o          out  32  instruction word
//   instr_pc_o       out  32  PC of instr_o
//   instr_ready_i    in   1   decode accepts instr_o
//   misalign_o       out  1   misaligned-target pulse (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async): state=IDLE, pc_q=RESET_PC, kill_q=0.
//     Outputs: imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0,
//     misalign_o=0, imem_addr_o=RESET_PC.
//   - redirect = take_branch_i | jump_i.
//     On redirect, in every state: pc_q <= target_i (aligned, see CONFIGURATION).
//   - FSM states: IDLE -> REQ -> WAIT -> HOLD -> REQ.
//     One outstanding request maximum.
//   - IDLE: req=0; advances to REQ next cycle unconditionally.
//     rvalid in IDLE is ignored.
//   - REQ: req=1, addr=pc_q.
//     gnt: -> WAIT, and kill_q <= redirect (same-cycle redirect kills this fetch).
//     No gnt + redirect: stay in REQ; addr shows the new target next cycle.
//     Address change before grant is legal for the core SRAM.
//   - WAIT: req=0.
//     rvalid & !kill_q & !redirect: instr_o<=rdata, instr_pc_o<=pc_q,
//       pc_q<=pc_q+4 (wraps mod 2^32), -> HOLD.
//     rvalid & (kill_q | redirect): discard the word, kill_q<=0, -> REQ.
//     No rvalid + redirect: kill_q<=1, stay in WAIT.
//   - HOLD: instr_valid_o=1; instr_o and instr_pc_o are stable.
//     ready & !redirect: -> REQ (valid=0 next cycle).
//     redirect, with or without ready: -> REQ, valid=0 next cycle.
//     If ready and redirect coincide, decode squashes its own stage.
//   - Throughput: 1 instruction per 3 cycles with zero-wait memory.
//     Latency: addr presented -> instr_valid_o is 2 cycles with gnt and rvalid
//     on consecutive cycles.
//   - All outputs are registered except imem_addr_o (= pc_q, also registered).
//   - Reset mid-transaction: a later rvalid for the abandoned request arrives
//     in IDLE or REQ and is ignored.
// CONFIGURATION
//   FETCH_MISALIGN_EN undefined:
//     target_i[1:0] forced to 2'b00; misalign_o tied 0.
//   FETCH_MISALIGN_EN defined:
//     redirect with target_i[1:0]!=0 -> misalign_o=1 for exactly 1 cycle,
//     misalign_o latches target_i into pc_q unmodified, FSM -> HALT.
//     HALT: req=0, valid=0; exit only by reset.
//     Redirect in the same cycle as entering HALT is ignored.
// TESTING
//   1. Reset release, zero-wait memory returning 32'h00000013:
//      addr 0x0,0x4,0x8 issued; instr_pc_o 0x0,0x4,0x8; valid every 3rd cycle.
//   2. Decode stalls (ready=0) for 5 cycles in HOLD:
//      instr_o/instr_pc_o stable, no imem_req_o; next fetch at held pc+4.
//   3. take_branch_i=1, target 0x100 while in WAIT:
//      returned word discarded, instr_valid_o stays 0, next addr = 0x100.
//   4. jump_i=1, target 0x200 in HOLD with ready=0:
//      valid drops next cycle, next addr = 0x200.
//   5. gnt held low 4 cycles, branch to 0x40 in cycle 2:
//      imem_addr_o switches to 0x40; first valid instr_pc_o = 0x40.
//   6. FETCH_MISALIGN_EN, target 0x102:
//      misalign_o high 1 cycle, then no requests until rst_ni pulse;
//      without the macro, fetch resumes at 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fetch_unit
// Purpose  : RV32I fetch stage. Issues one imem request at a time and hands
//            each word to decode over valid/ready. Branches and jumps redirect
//            the PC. Define FETCH_MISALIGN_EN to halt on misaligned targets.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        take_branch_i,
  input  logic        jump_i,
  input  logic [31:0] target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        misalign_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;

  logic        redirect;
  logic [31:0] target;
  logic        misalign_hit;

  assign redirect = take_branch_i | jump_i;

`ifdef FETCH_MISALIGN_EN
  assign target       = target_i;
  assign misalign_hit = redirect & (target_i[1:0] != 2'b00) & (state_q != S_HALT);
`else
  logic [1:0] unused_tgt_lo;
  assign unused_tgt_lo = target_i[1:0];
  assign target        = {target_i[31:2], 2'b00};
  assign misalign_hit  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    misalign_d = 1'b0;

    if (misalign_hit) begin
      state_d    = S_HALT;
      pc_d       = target;
      kill_d     = 1'b0;
      misalign_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_REQ;
          if (redirect) pc_d = target;
        end
        S_REQ: begin
          if (redirect) pc_d = target;
          if (imem_gnt_i) begin
            state_d = S_WAIT;
            kill_d  = redirect;
          end
        end
        S_WAIT: begin
          if (redirect) pc_d = target;
          if (imem_rvalid_i) begin
            if (kill_q | redirect) begin
              // wrong-path word: drop it and refetch from the current pc
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              instr_d    = imem_rdata_i;
              instr_pc_d = pc_q;
              pc_d       = pc_q + 32'd4;
              state_d    = S_HOLD;
            end
          end else if (redirect) begin
            kill_d = 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect) pc_d = target;
          if (instr_ready_i | redirect) state_d = S_REQ;
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign misalign_o    = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_fetch_unit
// Purpose  : Directed bench for fetch_unit with an imem responder model and a
//            queue of PCs that decode must see, in order.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        take_branch_i = 1'b0;
  logic        jump_i = 1'b0;
  logic [31:0] target_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;
  logic        misalign_o;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .take_branch_i (take_branch_i),
    .jump_i        (jump_i),
    .target_i      (target_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];

  // memory responder state
  bit          gnt_en    = 1'b1;
  int          rv_delay  = 0;
  bit          pend      = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_wait = 0;

  // memory image: address 0 holds NOP (0x13), other words are address-tagged
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return 32'h0000_0013 ^ {a[24:0], 7'd0};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic tick();
    logic [31:0] a;
    imem_gnt_i    = imem_req_o && gnt_en;
    imem_rvalid_i = pend && (pend_wait == 0);
    imem_rdata_i  = imem_rvalid_i ? mem_fn(pend_addr) : 32'hDEAD_BEEF;
    a = imem_addr_o;
    @(posedge clk);
    if (imem_rvalid_i) pend = 1'b0;
    else if (pend) pend_wait--;
    if (imem_gnt_i) begin
      pend      = 1'b1;
      pend_addr = a;
      pend_wait = rv_delay;
    end
    #1;
  endtask

  task automatic wait_valid(input int max, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      seen = instr_valid_o;
    end
    chk(seen, name, 32'(seen), 32'h1);
  endtask

  // per-cycle comparison against the expected delivery stream
  logic        prev_valid = 1'b0;
  logic [31:0] prev_instr = 32'h0;
  logic [31:0] prev_pc    = 32'h0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_ni) begin
      prev_valid = 1'b0;
    end else begin
      chk(!(imem_req_o && instr_valid_o), "req_valid_exclusive",
          32'({imem_req_o, instr_valid_o}), 32'h0);
      if (imem_req_o)
        chk(imem_addr_o[1:0] == 2'b00, "addr_aligned", imem_addr_o,
            {imem_addr_o[31:2], 2'b00});
`ifndef FETCH_MISALIGN_EN
      chk(!misalign_o, "misalign_tied_low", 32'(misalign_o), 32'h0);
`endif
      if (instr_valid_o) begin
        chk(instr_o == mem_fn(instr_pc_o), "instr_word", instr_o, mem_fn(instr_pc_o));
        if (prev_valid) begin
          chk(instr_pc_o == prev_pc && instr_o == prev_instr, "held_stable",
              instr_pc_o, prev_pc);
        end else if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_instr", instr_pc_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk(instr_pc_o == e, "instr_pc_order", instr_pc_o, e);
        end
      end
      prev_valid = instr_valid_o;
      prev_instr = instr_o;
      prev_pc    = instr_pc_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk(!imem_req_o,         "rst_req",      32'(imem_req_o),    32'h0);
    chk(!instr_valid_o,      "rst_valid",    32'(instr_valid_o), 32'h0);
    chk(instr_o == 32'h0,    "rst_instr",    instr_o,            32'h0);
    chk(instr_pc_o == 32'h0, "rst_instr_pc", instr_pc_o,         32'h0);
    chk(!misalign_o,         "rst_misalign", 32'(misalign_o),    32'h0);
    chk(imem_addr_o == 32'h0,"rst_addr",     imem_addr_o,        32'h0);

    // zero-wait memory: one instruction every third cycle
    rst_ni = 1'b1;
    instr_ready_i = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk(instr_valid_o == (i % 3 == 0), "t1_valid_cadence",
          32'(instr_valid_o), 32'(i % 3 == 0));
      if (i % 3 == 1)
        chk(imem_req_o && imem_addr_o == 32'(4 * (i / 3)), "t1_addr",
            imem_addr_o, 32'(4 * (i / 3)));
      if (i == 3) chk(instr_o == 32'h0000_0013, "t1_nop_word", instr_o, 32'h13);
    end

    // decode stall while holding pc 0x8
    instr_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk(instr_valid_o && !imem_req_o, "t2_stall_state",
          32'({imem_req_o, instr_valid_o}), 32'h1);
      chk(instr_pc_o == 32'h8, "t2_held_pc", instr_pc_o, 32'h8);
    end
    instr_ready_i = 1'b1;
    tick();
    chk(imem_req_o && imem_addr_o == 32'hC, "t2_next_addr", imem_addr_o, 32'hC);
    exp_q.push_back(32'hC);
    wait_valid(8, "t2_wait_valid");

    // branch while waiting for rvalid of 0x10
    tick();
    tick();
    take_branch_i = 1'b1;
    target_i = 32'h100;
    tick();
    take_branch_i = 1'b0;
    chk(!instr_valid_o, "t3_discard", 32'(instr_valid_o), 32'h0);
    chk(imem_req_o && imem_addr_o == 32'h100, "t3_redirect_addr", imem_addr_o, 32'h100);
    exp_q.push_back(32'h100);
    wait_valid(8, "t3_wait_valid");
    chk(instr_o == 32'h0000_8013, "t3_word", instr_o, 32'h0000_8013);

    // branch before a slow rvalid: the late word must be killed
    rv_delay = 2;
    tick();
    tick();
    take_branch_i = 1'b1;
    target_i = 32'h180;
    tick();
    take_branch_i = 1'b0;
    rv_delay = 0;
    chk(!imem_req_o && !instr_valid_o, "t3b_still_waiting",
        32'({imem_req_o, instr_valid_o}), 32'h0);
    tick();
    chk(!imem_req_o, "t3b_no_early_req", 32'(imem_req_o), 32'h0);
    tick();
    chk(imem_req_o && imem_addr_o == 32'h180, "t3b_refetch", imem_addr_o, 32'h180);
    exp_q.push_back(32'h180);
    wait_valid(8, "t3b_wait_valid");

    // jump in HOLD with decode stalled
    instr_ready_i = 1'b0;
    jump_i = 1'b1;
    target_i = 32'h200;
    tick();
    jump_i = 1'b0;
    chk(!instr_valid_o && imem_req_o && imem_addr_o == 32'h200, "t4_jump_addr",
        imem_addr_o, 32'h200);
    instr_ready_i = 1'b1;
    exp_q.push_back(32'h200);
    wait_valid(8, "t4_wait_valid");

    // ready and redirect together
    take_branch_i = 1'b1;
    target_i = 32'h300;
    tick();
    take_branch_i = 1'b0;
    chk(imem_req_o && imem_addr_o == 32'h300, "t4b_ready_redirect", imem_addr_o, 32'h300);
    exp_q.push_back(32'h300);
    wait_valid(8, "t4b_wait_valid");

    // grant held off for four request cycles, branch in the second
    gnt_en = 1'b0;
    tick();
    chk(imem_req_o && imem_addr_o == 32'h304, "t5_first_req", imem_addr_o, 32'h304);
    take_branch_i = 1'b1;
    target_i = 32'h40;
    tick();
    take_branch_i = 1'b0;
    chk(imem_req_o && imem_addr_o == 32'h40, "t5_addr_switch", imem_addr_o, 32'h40);
    tick();
    tick();
    chk(imem_req_o && imem_addr_o == 32'h40, "t5_req_held", imem_addr_o, 32'h40);
    gnt_en = 1'b1;
    exp_q.push_back(32'h40);
    wait_valid(8, "t5_wait_valid");

    // misaligned target
    instr_ready_i = 1'b0;
    jump_i = 1'b1;
    target_i = 32'h102;
    tick();
    jump_i = 1'b0;
    instr_ready_i = 1'b1;
`ifdef FETCH_MISALIGN_EN
    chk(misalign_o && !imem_req_o && !instr_valid_o, "t6_misalign_pulse",
        32'({misalign_o, imem_req_o, instr_valid_o}), 32'h4);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk(!misalign_o && !imem_req_o && !instr_valid_o, "t6_halted",
          32'({misalign_o, imem_req_o, instr_valid_o}), 32'h0);
    end
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    exp_q.push_back(32'h0);
    wait_valid(8, "t6_restart");
`else
    chk(imem_req_o && imem_addr_o == 32'h100 && !misalign_o, "t6_aligned_target",
        imem_addr_o, 32'h100);
    exp_q.push_back(32'h100);
    wait_valid(8, "t6_wait_valid");
`endif

    // reset with a request outstanding; its late rvalid lands in REQ
    rv_delay = 2;
    tick();
    tick();
    rst_ni = 1'b0;
    #1;
    chk(!imem_req_o && !instr_valid_o && imem_addr_o == 32'h0, "t7_async_reset",
        imem_addr_o, 32'h0);
    tick();
    rst_ni = 1'b1;
    rv_delay = 0;
    exp_q.push_back(32'h0);
    wait_valid(10, "t7_wait_valid");
    chk(instr_pc_o == 32'h0 && instr_o == 32'h0000_0013, "t7_fresh_fetch",
        instr_o, 32'h13);

    tick();
    chk(exp_q.size() == 0, "exp_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
